mem_control: RTL and testbench

MEM_CONTROL -- requirements
Module: mem_control

---
 rtl/mem_control_pkg.sv | 30 +++
 rtl/mem_control_wait_cnt.sv | 37 +++
 rtl/mem_control.sv | 171 +++++++++++++++++
 tb/tb_mem_control.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_control_pkg.sv
// -----------------------------------------------------------------------------
// mem_control_pkg
// Shared definitions for the SRAM memory controller slice:
//   - bus widths (RegBus, MemAddrBus, SRAM address)
//   - default NOP instruction returned while the fetch path is blocked
//   - controller state encodings
// -----------------------------------------------------------------------------
package mem_control_pkg;

  localparam int REG_BUS_W      = 16;
  localparam int MEM_ADDR_BUS_W = 16;
  localparam int SRAM_ADDR_W    = 18;

  localparam logic [REG_BUS_W-1:0] NOP_INST_DEFAULT = 16'h0800;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    R_ACCESS = 3'd1,
    W_SETUP  = 3'd2,
    W_PULSE  = 3'd3,
    W_HOLD   = 3'd4,
    DONE     = 3'd5
  } memStateT;

  // States whose length is stretched by the wait counter.
  function automatic logic isWaitState(input memStateT s);
    return (s == R_ACCESS) || (s == W_PULSE);
  endfunction

endpackage

// File: rtl/mem_control_wait_cnt.sv
// -----------------------------------------------------------------------------
// mem_control_wait_cnt
// 3-bit wait counter with a done flag. Counts up while enabled, returns to 0
// when cleared, and flags done when the count equals the loaded limit.
// Ports:
//   clk, rst  clock, asynchronous active-low reset
//   clear     force the count back to 0 on the next edge (wins over enable)
//   enable    advance the count
//   limit     terminal count (number of extra wait cycles)
//   done      count == limit
// -----------------------------------------------------------------------------
module mem_control_wait_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  input  logic [2:0] limit,
  output logic       done
);

  logic [2:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 3'd0;
    end else if (clear) begin
      count <= 3'd0;
    end else if (enable) begin
      count <= count + 3'd1;
    end
  end

  assign done = (count == limit);

endmodule

// File: rtl/mem_control.sv
// -----------------------------------------------------------------------------
// mem_control
// Asynchronous-SRAM controller sharing one 16-bit SRAM between the CPU fetch
// path and its load/store path. Data accesses stall the pipeline; the fetch
// path is served combinationally whenever no data access owns the SRAM.
// Parameters:
//   WAIT_CYCLES  extra SRAM access cycles beyond the first (0-7)
//   NOP_INST     instruction returned while fetch is blocked
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   inst_addr_i, inst_en_i        fetch request;  inst_data_o fetched word
//   mem_addr_i, mem_wdata_i       data address / store data
//   mem_we_i, mem_re_i            store / load request (store wins if both)
//   mem_rdata_o                   registered load result
//   stall_o                       pipeline pause request
//   sram_addr_o, sram_dq_o,
//   sram_dq_oe_o, sram_dq_i       SRAM address and split data bus
//   sram_ce_n_o, sram_oe_n_o,
//   sram_we_n_o                   SRAM strobes, active-low
// Optional build macro:
//   MEM_CONTROL_PERF_EN  adds perf_stall_cnt_o, a 32-bit count of stall cycles
// -----------------------------------------------------------------------------
module mem_control
  import mem_control_pkg::*;
#(
  parameter int                    WAIT_CYCLES = 1,
  parameter logic [REG_BUS_W-1:0]  NOP_INST    = NOP_INST_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [MEM_ADDR_BUS_W-1:0] inst_addr_i,
  input  logic                      inst_en_i,
  output logic [REG_BUS_W-1:0]      inst_data_o,
  input  logic [MEM_ADDR_BUS_W-1:0] mem_addr_i,
  input  logic [REG_BUS_W-1:0]      mem_wdata_i,
  input  logic                      mem_we_i,
  input  logic                      mem_re_i,
  output logic [REG_BUS_W-1:0]      mem_rdata_o,
  output logic                      stall_o,
  output logic [SRAM_ADDR_W-1:0]    sram_addr_o,
  output logic [REG_BUS_W-1:0]      sram_dq_o,
  output logic                      sram_dq_oe_o,
  input  logic [REG_BUS_W-1:0]      sram_dq_i,
  output logic                      sram_ce_n_o,
  output logic                      sram_oe_n_o,
  output logic                      sram_we_n_o
`ifdef MEM_CONTROL_PERF_EN
  ,
  output logic [31:0]               perf_stall_cnt_o
`endif
);

  localparam int PAD_W = SRAM_ADDR_W - MEM_ADDR_BUS_W;

  memStateT                  state;
  logic [MEM_ADDR_BUS_W-1:0] addrReg;
  logic [REG_BUS_W-1:0]      wdataReg;
  logic [REG_BUS_W-1:0]      rdataReg;
  logic                      waitRun;
  logic                      waitDone;
  logic                      stall;
  logic                      fetch;

  // The counter runs only inside the stretched states and is cleared on the
  // edge that leaves them, so it always reads 0 on entry to any state.
  assign waitRun = isWaitState(state);

  mem_control_wait_cnt u_wait_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (!waitRun || waitDone),
    .enable (waitRun),
    .limit  (3'(WAIT_CYCLES)),
    .done   (waitDone)
  );

  // Address and store data are captured when leaving IDLE so the SRAM sees a
  // stable bus for the whole access even if the CPU inputs wiggle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      addrReg  <= '0;
      wdataReg <= '0;
      rdataReg <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (mem_we_i) begin
            state    <= W_SETUP;
            addrReg  <= mem_addr_i;
            wdataReg <= mem_wdata_i;
          end else if (mem_re_i) begin
            state   <= R_ACCESS;
            addrReg <= mem_addr_i;
          end
        end
        R_ACCESS: begin
          if (waitDone) begin
            state    <= DONE;
            rdataReg <= sram_dq_i;
          end
        end
        W_SETUP: state <= W_PULSE;
        W_PULSE: if (waitDone) state <= W_HOLD;
        W_HOLD:  state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are decoded from the state register; everything is gated by rst
  // so the SRAM is released the instant reset asserts, without a clock edge.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves a signal unassigned and infers a latch.
    sram_addr_o  = {{PAD_W{1'b0}}, addrReg};
    sram_ce_n_o  = 1'b1;
    sram_oe_n_o  = 1'b1;
    sram_we_n_o  = 1'b1;
    sram_dq_oe_o = 1'b0;
    inst_data_o  = NOP_INST;
    stall        = 1'b0;
    fetch        = 1'b0;
    if (rst) begin
      unique case (state)
        IDLE: begin
          // A pending data request owns the SRAM from the next edge on.
          if (mem_we_i || mem_re_i) stall = 1'b1;
          else                      fetch = 1'b1;
        end
        DONE: fetch = 1'b1;
        R_ACCESS: begin
          stall       = 1'b1;
          sram_ce_n_o = 1'b0;
          sram_oe_n_o = 1'b0;
        end
        W_SETUP, W_HOLD: begin
          stall        = 1'b1;
          sram_ce_n_o  = 1'b0;
          sram_dq_oe_o = 1'b1;
        end
        W_PULSE: begin
          stall        = 1'b1;
          sram_ce_n_o  = 1'b0;
          sram_dq_oe_o = 1'b1;
          sram_we_n_o  = 1'b0;
        end
        default: ;
      endcase
      if (fetch) begin
        sram_addr_o = {{PAD_W{1'b0}}, inst_addr_i};
        sram_ce_n_o = !inst_en_i;
        sram_oe_n_o = !inst_en_i;
        if (inst_en_i) inst_data_o = sram_dq_i;
      end
    end
  end

  assign sram_dq_o   = wdataReg;
  assign mem_rdata_o = rdataReg;
  assign stall_o     = stall;

`ifdef MEM_CONTROL_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) perf_stall_cnt_o <= '0;
    else      perf_stall_cnt_o <= perf_stall_cnt_o + 32'(stall);
  end
`endif

endmodule

// File: tb/tb_mem_control.sv
// -----------------------------------------------------------------------------
// tb_mem_control
// Self-checking bench for mem_control (WAIT_CYCLES=1). A behavioural SRAM
// answers reads and captures writes. Data accesses come from a vector table;
// each expected load result is queued when the request is driven and popped
// when the controller reaches its non-stalled DONE cycle.
// -----------------------------------------------------------------------------
module tb_mem_control;

  localparam int          WAIT = 1;
  localparam logic [15:0] NOP  = 16'h0800;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] inst_addr_i;
  logic        inst_en_i;
  logic [15:0] inst_data_o;
  logic [15:0] mem_addr_i;
  logic [15:0] mem_wdata_i;
  logic        mem_we_i;
  logic        mem_re_i;
  logic [15:0] mem_rdata_o;
  logic        stall_o;
  logic [17:0] sram_addr_o;
  logic [15:0] sram_dq_o;
  logic        sram_dq_oe_o;
  logic [15:0] sram_dq_i;
  logic        sram_ce_n_o;
  logic        sram_oe_n_o;
  logic        sram_we_n_o;
`ifdef MEM_CONTROL_PERF_EN
  logic [31:0] perf_stall_cnt_o;
`endif

  mem_control #(.WAIT_CYCLES(WAIT), .NOP_INST(NOP)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_addr_i  (inst_addr_i),
    .inst_en_i    (inst_en_i),
    .inst_data_o  (inst_data_o),
    .mem_addr_i   (mem_addr_i),
    .mem_wdata_i  (mem_wdata_i),
    .mem_we_i     (mem_we_i),
    .mem_re_i     (mem_re_i),
    .mem_rdata_o  (mem_rdata_o),
    .stall_o      (stall_o),
    .sram_addr_o  (sram_addr_o),
    .sram_dq_o    (sram_dq_o),
    .sram_dq_oe_o (sram_dq_oe_o),
    .sram_dq_i    (sram_dq_i),
    .sram_ce_n_o  (sram_ce_n_o),
    .sram_oe_n_o  (sram_oe_n_o),
    .sram_we_n_o  (sram_we_n_o)
`ifdef MEM_CONTROL_PERF_EN
    ,
    .perf_stall_cnt_o (perf_stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: asynchronous read, write captured while ce_n/we_n low.
  logic [15:0] sramMem [0:65535];
  logic        preloadEn = 1'b0;
  logic [15:0] preloadAddr = 16'h0;
  logic [15:0] preloadData = 16'h0;

  always @(posedge clk) begin
    if (preloadEn)                         sramMem[preloadAddr] <= preloadData;
    else if (!sram_ce_n_o && !sram_we_n_o) sramMem[sram_addr_o[15:0]] <= sram_dq_o;
  end
  assign sram_dq_i = sramMem[sram_addr_o[15:0]];

  typedef struct {
    logic        we;
    logic        re;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          expStall;
    int          expWeLow;
    int          expOeLow;
    int          expDqOe;
    logic [15:0] expRdata;
  } vecT;

  vecT         vecs [8];
  logic [15:0] sb [$];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic failTimeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for the controller", name);
  endtask

  // Issue one data request at posedge+1 and follow it until stall_o drops.
  // Returns in the DONE cycle with the request still applied.
  task automatic doAccess(input vecT v, input string tag);
    int   stallCnt = 0, weLow = 0, oeLow = 0, dqOe = 0;
    int   overlap = 0, dqBad = 0, addrBad = 0, nopBad = 0;
    logic finished = 1'b0;
    @(posedge clk); #1;
    mem_we_i    = v.we;
    mem_re_i    = v.re;
    mem_addr_i  = v.addr;
    mem_wdata_i = v.wdata;
    sb.push_back(v.expRdata);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!stall_o) begin
        finished = 1'b1;
        break;
      end
      stallCnt++;
      if (!sram_we_n_o) weLow++;
      if (!sram_oe_n_o) oeLow++;
      if (sram_dq_oe_o) dqOe++;
      if (!sram_we_n_o && !sram_oe_n_o) overlap++;
      if (sram_dq_oe_o && !sram_oe_n_o) overlap++;
      if (sram_dq_oe_o && sram_dq_o !== v.wdata) dqBad++;
      if ((sram_dq_oe_o || !sram_oe_n_o) && sram_addr_o !== {2'b00, v.addr}) addrBad++;
      if (inst_data_o !== NOP) nopBad++;
    end
    if (!finished) begin
      failTimeout({tag, " stall"});
      void'(sb.pop_front());
    end else begin
      check({tag, " stall cycles"}, stallCnt, v.expStall);
      check({tag, " we_n low cycles"}, weLow, v.expWeLow);
      check({tag, " oe_n low cycles"}, oeLow, v.expOeLow);
      check({tag, " dq_oe cycles"}, dqOe, v.expDqOe);
      check({tag, " strobe overlap"}, overlap, 0);
      check({tag, " dq unstable"}, dqBad, 0);
      check({tag, " addr unstable"}, addrBad, 0);
      check({tag, " nop while stalled"}, nopBad, 0);
      check({tag, " rdata"}, mem_rdata_o, sb.pop_front());
      check({tag, " fetch in DONE"}, inst_data_o, 16'h4F01);
      check({tag, " fetch addr in DONE"}, sram_addr_o, 18'h00010);
    end
  endtask

  initial begin
    logic found;
    // Loads stall WAIT+2, stores WAIT+4; we_n low WAIT+1 for stores.
    vecs[0] = '{1'b0, 1'b1, 16'h0123, 16'h0000, 3, 0, 2, 0, 16'hBEEF};
    vecs[1] = '{1'b1, 1'b0, 16'h0040, 16'hA5A5, 5, 2, 0, 4, 16'hBEEF};
    vecs[2] = '{1'b0, 1'b1, 16'h0040, 16'h0000, 3, 0, 2, 0, 16'hA5A5};
    vecs[3] = '{1'b1, 1'b1, 16'h0050, 16'h1234, 5, 2, 0, 4, 16'hA5A5};
    vecs[4] = '{1'b0, 1'b1, 16'h0050, 16'h0000, 3, 0, 2, 0, 16'h1234};
    vecs[5] = '{1'b1, 1'b0, 16'h0123, 16'h0F0F, 5, 2, 0, 4, 16'h1234};
    vecs[6] = '{1'b0, 1'b1, 16'h0123, 16'h0000, 3, 0, 2, 0, 16'h0F0F};
    vecs[7] = '{1'b0, 1'b1, 16'h0040, 16'h0000, 3, 0, 2, 0, 16'hA5A5};

    // Reset with a store request and fetch enable present.
    rst         = 1'b0;
    inst_addr_i = 16'h0010;
    inst_en_i   = 1'b1;
    mem_addr_i  = 16'h0000;
    mem_wdata_i = 16'h0000;
    mem_we_i    = 1'b1;
    mem_re_i    = 1'b0;
    @(negedge clk);
    preloadEn = 1'b1; preloadAddr = 16'h0010; preloadData = 16'h4F01;
    @(negedge clk);
    preloadAddr = 16'h0123; preloadData = 16'hBEEF;
    @(negedge clk);
    preloadEn = 1'b0;
    #1;
    check("reset stall", stall_o, 0);
    check("reset we_n", sram_we_n_o, 1);
    check("reset oe_n", sram_oe_n_o, 1);
    check("reset ce_n", sram_ce_n_o, 1);
    check("reset dq_oe", sram_dq_oe_o, 0);
    check("reset rdata", mem_rdata_o, 16'h0000);
    check("reset inst", inst_data_o, NOP);
    mem_we_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Fetch-only traffic: combinational instruction return.
    @(negedge clk);
    check("fetch stall", stall_o, 0);
    check("fetch data", inst_data_o, 16'h4F01);
    check("fetch addr", sram_addr_o, 18'h00010);
    check("fetch oe_n", sram_oe_n_o, 0);
    inst_addr_i = 16'h0123;
    #1;
    check("fetch data comb", inst_data_o, 16'hBEEF);
    inst_en_i = 1'b0;
    #1;
    check("fetch disabled inst", inst_data_o, NOP);
    check("fetch disabled oe_n", sram_oe_n_o, 1);
    check("fetch disabled ce_n", sram_ce_n_o, 1);
    inst_addr_i = 16'h0010;
    inst_en_i   = 1'b1;

    // Table: back-to-back data accesses with fetch running in between.
    for (int i = 0; i < 8; i++) doAccess(vecs[i], $sformatf("vec%0d", i));
    @(posedge clk); #1;
    mem_we_i = 1'b0;
    mem_re_i = 1'b0;
    @(negedge clk);
    check("idle after table stall", stall_o, 0);

    // Reset asserted mid write pulse releases the SRAM without a clock edge.
    @(posedge clk); #1;
    mem_we_i = 1'b1; mem_addr_i = 16'h0060; mem_wdata_i = 16'h7777;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!sram_we_n_o) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) failTimeout("pulse entry");
    #2;
    rst = 1'b0;
    #1;
    check("mid reset we_n", sram_we_n_o, 1);
    check("mid reset ce_n", sram_ce_n_o, 1);
    check("mid reset oe_n", sram_oe_n_o, 1);
    check("mid reset dq_oe", sram_dq_oe_o, 0);
    check("mid reset stall", stall_o, 0);
    check("mid reset rdata", mem_rdata_o, 16'h0000);
    check("mid reset inst", inst_data_o, NOP);
    mem_we_i = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Release with a load already pending: the first edge must take it.
    rst = 1'b1; mem_re_i = 1'b1; mem_addr_i = 16'h0050;
    #1;
    check("post reset stall", stall_o, 1);
    @(posedge clk); #1;
    check("first edge read strobe", sram_oe_n_o, 0);
    check("first edge read addr", sram_addr_o, 18'h00050);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!stall_o) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) failTimeout("post reset load");
    else        check("post reset rdata", mem_rdata_o, 16'h1234);
    @(posedge clk); #1;
    mem_re_i = 1'b0;
    @(negedge clk);
    check("final fetch", inst_data_o, 16'h4F01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
